fir_out_quantizer: RTL and testbench
====================================

Name: fir_out_quantizer

Overview:
Downstream stage of the 5-tap high-pass FIR top.
- Consumes the 24-bit signed filter output every valid clock.
- Rounds and arithmetic-shifts it to 16 bits, then saturates.
- Buffers results in a small FIFO that presents a valid/ready stream to the next consumer (DAC/serializer). Sticky flags report clipping and overflow.

Parameters:
SHIFT, 8, right-shift applied to y_in before saturation (legal range 1..8).
DEPTH, 8, FIFO depth in entries (power of two, 2..32).
AW, 3, FIFO address width; must equal log2(DEPTH).

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
y_in  input  24  signed FIR output (two's complement).
in_valid  input  1  y_in is valid this cycle; FIR top drives it high continuously.
clr_flags  input  1  synchronous clear of sat_flag and ovf_flag.
out_data  output  16  signed quantized sample at FIFO head.
out_valid  output  1  FIFO non-empty.
out_ready  input  1  consumer accepts out_data this cycle.
level  output  AW+1  current FIFO occupancy, 0..DEPTH.
sat_flag  output  1  sticky: at least one sample clipped.
ovf_flag  output  1  sticky: at least one sample dropped because FIFO full.

Behaviour:
- Reset (async assert, sync-to-clk deassert not required): out_valid=0, out_data=0, level=0, sat_flag=0, ovf_flag=0; pointers and stage register cleared; stage-valid=0. Reset mid-operation discards all buffered data immediately.
- Stage 1 (quantize), on clk when in_valid=1:
  - sum = sign-extend(y_in to 25 b) + (1 << (SHIFT-1)); q = sum >>> SHIFT (arithmetic).
  - If q > 32767 then q = 32767. If q < -32768 then q = -32768. Either case asserts sat_pulse.
  - Registers q and stage-valid=1. When in_valid=0, stage-valid=0.
- Stage 2 (FIFO write), on clk when stage-valid=1:
  - Write when level<DEPTH, or when level==DEPTH and a read happens in the same cycle.
  - Otherwise drop the sample and set ovf_flag.
- Read: fires when out_valid && out_ready. Advances rd_ptr. A read while empty is ignored and does not underflow.
- Simultaneous read+write: level unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. level is a registered count.
- out_data = mem[rd_ptr] (registered array, combinational read). out_data holds the last value when empty; consumers ignore it when out_valid=0.
- Latency:
  - in_valid sampled at edge N: stage reg updated at N, FIFO written at N+1.
  - Into an empty FIFO, out_valid=1 after edge N+1.
- Flags:
  - sat_flag is set the cycle after sat_pulse. ovf_flag is set at the dropping edge.
  - clr_flags=1 clears both flags. If set and clear occur in the same cycle, set wins.
- Throughput: one sample per clock sustained when out_ready=1.

Optional Feature:
FIR_SAT_CNT_EN
- Defined:
  - Adds output port sat_count [15:0].
  - Increments on each saturating sample and saturates at 0xFFFF; no wrap.
  - Cleared by reset and by clr_flags. Clear beats increment in the same cycle.
- Undefined: no port, no counter logic. All other behaviour is identical.

Test Plan:
- Rounding, SHIFT=8, out_ready=1. Stimulus: y_in = 0x000180, 0x00017F, 0xFFFF80, 0xFFFF7F. Required: out_data = 2, 1, 0, -1 in order; sat_flag=0.
- Saturation. Stimulus: y_in = 0x7FFFFF, then 0x800000. Required: out_data = 32767 with sat_flag=1 after the first; then -32768 (exact, no clip). If FIR_SAT_CNT_EN is defined, sat_count=1.
- Latency. Stimulus: a single in_valid pulse at edge N into an empty FIFO. Required: out_valid rises after edge N+1; level=1; cleared by one read.
- Overflow. Stimulus: out_ready=0, 10 consecutive valid samples 1..10 (y_in = k<<8). Required: level saturates at 8; ovf_flag=1; draining yields 1..8. Then clr_flags clears ovf_flag.
- Full with simultaneous read/write. Stimulus: FIFO full, out_ready=1 while continuous input runs. Required: level stays 8, ovf_flag stays 0, output order preserved.
- Reset mid-stream. Stimulus: reset_n low for 10 ns with level=5. Required: out_valid=0, level=0, flags=0 immediately. The first sample after release appears with normal latency.

Source files
------------

// File: rtl/fir_out_quantizer_if.sv
// Sample-in / stream-out signal bundle between the FIR top, fir_out_quantizer and its consumer.
interface fir_out_quantizer_if;
  logic [23:0] y_in;
  logic        in_valid;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport slave (input y_in, in_valid, out_ready, output out_data, out_valid);
  modport master (output y_in, in_valid, out_ready, input out_data, out_valid);
endinterface

// File: rtl/fir_out_quantizer.sv
// Round/shift/saturate 24-bit FIR output to 16 bits and buffer it in a small valid/ready FIFO.
// Optional build macro FIR_SAT_CNT_EN adds a saturating 16-bit clip counter port (sat_count).
module fir_out_quantizer #(
  parameter int SHIFT = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  fir_out_quantizer_if.slave  s,
  input  logic                clr_flags,
  output logic [AW:0]         level,
  output logic                sat_flag,
  output logic                ovf_flag
`ifdef FIR_SAT_CNT_EN
  ,
  output logic [15:0]         sat_count
`endif
);

  localparam logic signed [24:0] ROUND = 25'(1) << (SHIFT - 1);
  localparam logic signed [24:0] Q_MAX = 25'sd32767;
  localparam logic signed [24:0] Q_MIN = -25'sd32768;
  localparam logic [AW:0]        FULL  = (AW + 1)'(DEPTH);

  logic signed [24:0] sum;
  logic signed [24:0] shifted;
  logic [15:0]        q_sat;
  logic               sat_pulse;

  logic               stage_valid_q;
  logic [15:0]        stage_data_q;
  logic               stage_sat_q;

  logic [15:0]        mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        level_q, level_d;
  logic               sat_q, sat_d;
  logic               ovf_q, ovf_d;
  logic               rd_en, wr_en, drop;

  always_comb begin
    sum       = {s.y_in[23], s.y_in} + ROUND;
    shifted   = sum >>> SHIFT;
    q_sat     = shifted[15:0];
    sat_pulse = 1'b0;
    if (shifted > Q_MAX) begin
      q_sat     = 16'h7FFF;
      sat_pulse = 1'b1;
    end else if (shifted < Q_MIN) begin
      q_sat     = 16'h8000;
      sat_pulse = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_valid_q <= 1'b0;
      stage_data_q  <= '0;
      stage_sat_q   <= 1'b0;
    end else begin
      stage_valid_q <= s.in_valid;
      if (s.in_valid) begin
        stage_data_q <= q_sat;
        stage_sat_q  <= sat_pulse;
      end
    end
  end

  // A full FIFO still accepts a write when the head is popped on the same edge.
  always_comb begin
    rd_en   = (level_q != '0) && s.out_ready;
    wr_en   = stage_valid_q && ((level_q != FULL) || rd_en);
    drop    = stage_valid_q && !wr_en;
    level_d = level_q;
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    sat_d = (stage_valid_q && stage_sat_q) || (sat_q && !clr_flags);
    ovf_d = drop || (ovf_q && !clr_flags);
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          mem_q[gi] <= '0;
        end else if (wr_en && (wr_ptr_q == AW'(gi))) begin
          mem_q[gi] <= stage_data_q;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      sat_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef FIR_SAT_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_flags) begin
      cnt_d = '0;
    end else if (stage_valid_q && stage_sat_q && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign sat_count = cnt_q;
`endif

  assign s.out_data  = mem_q[rd_ptr_q];
  assign s.out_valid = (level_q != '0);
  assign level       = level_q;
  assign sat_flag    = sat_q;
  assign ovf_flag    = ovf_q;

endmodule

// File: tb/tb_fir_out_quantizer.sv
// Directed bench for fir_out_quantizer: vector table plus FIFO overflow, full read/write and reset sequences.
module tb_fir_out_quantizer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clr_flags;
  logic [3:0] level;
  logic       sat_flag;
  logic       ovf_flag;
`ifdef FIR_SAT_CNT_EN
  logic [15:0] sat_count;
`endif

  fir_out_quantizer_if bus();

  fir_out_quantizer #(.SHIFT(8), .DEPTH(8), .AW(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s         (bus),
    .clr_flags (clr_flags),
    .level     (level),
    .sat_flag  (sat_flag),
    .ovf_flag  (ovf_flag)
`ifdef FIR_SAT_CNT_EN
    ,
    .sat_count (sat_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] y;
    int          q;
    bit          sat;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int dout();
    return int'($signed(bus.out_data));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int got[$];
    int expv;

    reset_n       = 1'b0;
    clr_flags     = 1'b0;
    bus.y_in      = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    vecs[0] = '{24'h000180,  2,     1'b0};
    vecs[1] = '{24'h00017F,  1,     1'b0};
    vecs[2] = '{24'hFFFF80,  0,     1'b0};
    vecs[3] = '{24'hFFFF7F, -1,     1'b0};
    vecs[4] = '{24'h7FFFFF,  32767, 1'b1};
    vecs[5] = '{24'h800000, -32768, 1'b0};
    vecs[6] = '{24'h7FFF7F,  32767, 1'b0};
    vecs[7] = '{24'h7FFF80,  32767, 1'b1};
    vecs[8] = '{24'h001234,  18,    1'b0};
    vecs[9] = '{24'hFF8000, -128,   1'b0};

    #12;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", dout(), 0);
    chk("rst_level", level, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_ovf", ovf_flag, 0);
    reset_n = 1'b1;
    tick();

    // One sample at a time: latency, value, flag, then read + clear.
    for (int i = 0; i < NV; i++) begin
      bus.y_in     = vecs[i].y;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk($sformatf("v%0d_lat", i), bus.out_valid, 0);
      tick();
      chk($sformatf("v%0d_valid", i), bus.out_valid, 1);
      chk($sformatf("v%0d_data", i), dout(), vecs[i].q);
      chk($sformatf("v%0d_sat", i), sat_flag, int'(vecs[i].sat));
      chk($sformatf("v%0d_level", i), level, 1);
`ifdef FIR_SAT_CNT_EN
      chk($sformatf("v%0d_cnt", i), sat_count, int'(vecs[i].sat));
`endif
      bus.out_ready = 1'b1;
      clr_flags     = 1'b1;
      tick();
      chk($sformatf("v%0d_empty", i), bus.out_valid, 0);
      chk($sformatf("v%0d_clr", i), sat_flag, 0);
      bus.out_ready = 1'b0;
      clr_flags     = 1'b0;
    end

    // Back-to-back rounding samples with the consumer always ready.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.y_in     = vecs[i].y;
      bus.in_valid = 1'b1;
      tick();
      if (bus.out_valid) got.push_back(dout());
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.out_valid) got.push_back(dout());
    end
    chk("stream_count", got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stream_%0d", i), (i < got.size()) ? got[i] : 99999, vecs[i].q);
    end
    chk("stream_sat", sat_flag, 0);

    // Overflow: 10 samples into a stalled 8-deep FIFO.
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      bus.y_in     = 24'(k * 256);
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    chk("ovf_level", level, 8);
    chk("ovf_flag", ovf_flag, 1);
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("ovf_drain_%0d", k), dout(), k);
      tick();
    end
    chk("ovf_drained_level", level, 0);
    chk("ovf_drained_valid", bus.out_valid, 0);
    chk("ovf_sticky", ovf_flag, 1);
    bus.out_ready = 1'b0;
    clr_flags     = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("ovf_cleared", ovf_flag, 0);

    // Full FIFO with continuous input and a ready consumer.
    for (int k = 1; k <= 9; k++) begin
      bus.y_in     = 24'(k * 256);
      bus.in_valid = 1'b1;
      tick();
    end
    chk("full_level", level, 8);
    chk("full_ovf", ovf_flag, 0);
    bus.out_ready = 1'b1;
    expv = 1;
    for (int k = 10; k <= 19; k++) begin
      bus.y_in = 24'(k * 256);
      chk($sformatf("full_pop_%0d", expv), dout(), expv);
      expv++;
      tick();
      chk($sformatf("full_lvl_%0d", k), level, 8);
      chk($sformatf("full_ovf_%0d", k), ovf_flag, 0);
    end
    bus.in_valid = 1'b0;
    for (int t = 0; t < 12 && bus.out_valid; t++) begin
      chk($sformatf("full_pop_%0d", expv), dout(), expv);
      expv++;
      tick();
    end
    chk("full_total", expv, 20);
    chk("full_end_level", level, 0);
    chk("full_end_ovf", ovf_flag, 0);

    // Reset with 5 entries buffered and sat_flag set.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.y_in     = (k == 0) ? 24'h7FFFFF : 24'(k * 256);
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    chk("pre_rst_level", level, 5);
    chk("pre_rst_sat", sat_flag, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_sat", sat_flag, 0);
    chk("mid_rst_ovf", ovf_flag, 0);
    chk("mid_rst_data", dout(), 0);
`ifdef FIR_SAT_CNT_EN
    chk("mid_rst_cnt", sat_count, 0);
`endif
    #9 reset_n = 1'b1;
    tick();
    chk("post_rst_level", level, 0);
    bus.y_in     = 24'h000180;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("post_rst_lat", bus.out_valid, 0);
    tick();
    chk("post_rst_valid", bus.out_valid, 1);
    chk("post_rst_data", dout(), 2);
    chk("post_rst_lvl1", level, 1);
    bus.out_ready = 1'b1;
    tick();
    chk("post_rst_read", level, 0);
    bus.out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
